piso_bit_feeder: RTL and testbench
==================================

Name: piso_bit_feeder

Overview:
Parallel-in, serial-out feeder sitting directly upstream of the serial sequence detectors in the FSM group. It accepts WIDTH-bit words over a valid/ready handshake and drives the single-bit serial stream `x` that a detector samples on every clock edge. A one-word holding buffer lets consecutive words stream with no idle gap. `x` is forced to 0 whenever no valid bit is present.

Parameters:
- WIDTH, 8, word width in bits (legal range 2..32).
- MSB_FIRST, 1, 1 = bit WIDTH-1 is sent first; 0 = bit 0 is sent first.

Ports:
- clk  input  1  single clock; all logic on rising edge.
- rst  input  1  asynchronous, active-high reset.
- din  input  WIDTH  parallel word.
- din_valid  input  1  upstream word present.
- din_ready  output  1  feeder can accept; equals !hold_full (combinational from registered state).
- x  output  1  registered serial bit; 0 when x_valid=0.
- x_valid  output  1  x carries a real bit this cycle.
- busy  output  1  shifting, or hold buffer occupied.
- word_done  output  1  one-cycle pulse coincident with the final serial bit of a word.

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-high (rst).
- Reset values:
  - x=0, x_valid=0, word_done=0, busy=0.
  - hold_full=0, so din_ready=1.
  - state=IDLE, bit_cnt=0, shift register and hold register cleared.
- Accept rule: a transfer occurs at an edge where din_valid && din_ready.
- State machine:
  - IDLE:
    - x=0, x_valid=0.
    - On accept, the word loads directly into the shift register, bit_cnt=0, next state SHIFT.
    - Latency: first bit appears on x in the cycle after the accept edge.
  - SHIFT:
    - x_valid=1; one bit per cycle in MSB_FIRST order.
    - bit_cnt increments from 0 to WIDTH-1.
    - An accept during SHIFT writes the hold register (hold_full=1).
  - Last bit (bit_cnt==WIDTH-1): word_done=1 this cycle. At the closing edge:
    - if hold_full: move hold into the shift register, clear hold_full, stay in SHIFT, bit_cnt=0. No gap cycle.
    - else if an accept occurs at this same edge: bypass the word straight into the shift register, stay in SHIFT. No gap.
    - else: go to IDLE; x returns to 0 on the next cycle.
  - PARITY (only with the optional feature): see below.
- Hold buffer:
  - Depth 1. din_ready=0 while hold_full.
  - A new accept can never coincide with a full hold, so no overwrite is possible.
- busy = (state!=IDLE) || hold_full.
- Reset mid-word: the partial word and the hold contents are discarded. Outputs go to reset values immediately, with no further bits.
- A steady din_valid with back-to-back words gives continuous x_valid.
- The downstream detector sees idle zeros between bursts; this is intended.

Optional Feature:
- Macro: PISO_PARITY_EN.
- Defined:
  - After the last data bit, the FSM enters PARITY for one cycle, with x = even parity (XOR of all WIDTH bits of the word) and x_valid=1.
  - word_done moves to the PARITY cycle; the last data bit does not pulse.
  - Hold transfer or bypass happens at the PARITY closing edge instead.
  - Per-word length is WIDTH+1 cycles.
- Undefined: no PARITY state; per-word length is WIDTH cycles; no parity logic is synthesised.

Decomposition:
- Package piso_pkg contains:
  - state encoding constants ST_IDLE=2'd0, ST_SHIFT=2'd1, ST_PARITY=2'd2;
  - a width-of-counter helper constant: bit_cnt width = clog2(WIDTH) evaluated for the default.
- One sub-module is natural: piso_hold_buf. It holds the single-entry register with its full flag, and exposes write/read strobes and din_ready.
- The FSM, shift register and counter stay in piso_bit_feeder.

Test Plan:
- Single word: after reset, WIDTH=8, MSB_FIRST=1, din=8'hA8 with one-cycle valid.
  - x = 1,0,1,0,1,0,0,0 over 8 cycles, starting the cycle after the accept.
  - word_done only on the 8th cycle; x_valid=0 and x=0 afterwards.
- Back-to-back: din_valid held high with 8'hAA, 8'h55, 8'hFF.
  - 24 contiguous x_valid cycles.
  - din_ready drops after the second accept and rises one cycle after each hold transfer.
  - word_done on cycles 8, 16 and 24.
- Bypass at last bit: present 8'h0F exactly at the closing edge of a prior word, with hold empty.
  - No gap cycle; the new word starts the next cycle.
- Asynchronous reset mid-word: assert rst (not aligned to clk) during bit 3 of 8'hA8, with a word in hold.
  - x, x_valid, busy drop immediately; din_ready=1.
  - After release, no residual bits are emitted.
- LSB first: MSB_FIRST=0, din=8'hA8 → x = 0,0,0,1,0,1,0,1.
- Parity: with PISO_PARITY_EN, din=8'hA8 → 8 data bits, then parity bit 1 on cycle 9.
  - word_done on cycle 9 only; a back-to-back second word starts on cycle 10.

Source files
------------

// File: rtl/piso_pkg.sv
// Shared encodings and sizing helpers for the PISO bit feeder.
package piso_pkg;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SHIFT  = 2'd1;
  localparam logic [1:0] ST_PARITY = 2'd2;

  typedef enum logic [1:0] {
    StIdle   = ST_IDLE,
    StShift  = ST_SHIFT,
    StParity = ST_PARITY
  } state_e;

  localparam int unsigned DefaultWidth    = 8;
  localparam int unsigned DefaultCntWidth = $clog2(DefaultWidth);

  // Counter width for an arbitrary word width; never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/piso_hold_buf.sv
// Single-entry holding register with full flag; ready is the complement of full.
module piso_hold_buf #(
  parameter int unsigned Width = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             wr_i,
  input  logic [Width-1:0] wr_data_i,
  input  logic             rd_i,
  output logic [Width-1:0] rd_data_o,
  output logic             full_o,
  output logic             ready_o
);

  logic             full_q, full_d;
  logic [Width-1:0] data_q, data_d;

  always_comb begin
    full_d = full_q;
    data_d = data_q;
    if (wr_i) begin
      data_d = wr_data_i;
      full_d = 1'b1;
    end else if (rd_i) begin
      full_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      full_q <= 1'b0;
      data_q <= '0;
    end else begin
      full_q <= full_d;
      data_q <= data_d;
    end
  end

  assign rd_data_o = data_q;
  assign full_o    = full_q;
  assign ready_o   = ~full_q;

endmodule

// File: rtl/piso_bit_feeder.sv
// Parallel-in serial-out feeder with a one-word hold buffer for gapless streaming.
// Define PISO_PARITY_EN to append an even-parity bit after each word.
module piso_bit_feeder
  import piso_pkg::*;
#(
  parameter int unsigned WIDTH     = 8,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             x,
  output logic             x_valid,
  output logic             busy,
  output logic             word_done
);

  localparam int unsigned     CntW    = cnt_width(WIDTH);
  localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  shift_q, shift_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              x_q, x_d;
  logic              xv_q, xv_d;
  logic              done_q, done_d;

  logic              hold_full, hold_ready, hold_wr, hold_rd;
  logic [WIDTH-1:0]  hold_data;
  logic              accept, last_data, word_end, load_din;

  piso_hold_buf #(
    .Width (WIDTH)
  ) u_hold (
    .clk_i     (clk),
    .rst_i     (rst),
    .wr_i      (hold_wr),
    .wr_data_i (din),
    .rd_i      (hold_rd),
    .rd_data_o (hold_data),
    .full_o    (hold_full),
    .ready_o   (hold_ready)
  );

  function automatic logic head_bit(input logic [WIDTH-1:0] s);
    return MSB_FIRST ? s[WIDTH-1] : s[0];
  endfunction

  assign accept    = din_valid & hold_ready;
  assign last_data = (state_q == StShift) && (cnt_q == LastCnt);
`ifdef PISO_PARITY_EN
  assign word_end  = (state_q == StParity);
`else
  assign word_end  = last_data;
`endif
  // A word enters the shift register directly when idle or when bypassing at the closing edge.
  assign load_din  = accept && ((state_q == StIdle) || (word_end && !hold_full));
  assign hold_wr   = accept && !load_din;
  assign hold_rd   = word_end && hold_full;

`ifdef PISO_PARITY_EN
  logic par_q, par_d;

  always_comb begin
    par_d = par_q;
    if (load_din) begin
      par_d = ^din;
    end else if (hold_rd) begin
      par_d = ^hold_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      par_q <= 1'b0;
    end else begin
      par_q <= par_d;
    end
  end
`endif

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    cnt_d   = cnt_q;

    unique case (state_q)
      StShift: begin
        if (!last_data) begin
          shift_d = MSB_FIRST ? {shift_q[WIDTH-2:0], 1'b0} : {1'b0, shift_q[WIDTH-1:1]};
          cnt_d   = cnt_q + CntW'(1);
        end
`ifdef PISO_PARITY_EN
        else begin
          state_d = StParity;
        end
`endif
      end
      default: ;
    endcase

    if (hold_rd) begin
      shift_d = hold_data;
      cnt_d   = '0;
      state_d = StShift;
    end else if (load_din) begin
      shift_d = din;
      cnt_d   = '0;
      state_d = StShift;
    end else if (word_end) begin
      state_d = StIdle;
    end
  end

  // Outputs are registered: compute what the next cycle presents from the next state.
  always_comb begin
    x_d    = 1'b0;
    xv_d   = (state_d != StIdle);
    done_d = 1'b0;
    unique case (state_d)
      StShift: x_d = head_bit(shift_d);
`ifdef PISO_PARITY_EN
      StParity: x_d = par_d;
`endif
      default: x_d = 1'b0;
    endcase
`ifdef PISO_PARITY_EN
    done_d = (state_d == StParity);
`else
    done_d = (state_d == StShift) && (cnt_d == LastCnt);
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      shift_q <= '0;
      cnt_q   <= '0;
      x_q     <= 1'b0;
      xv_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      x_q     <= x_d;
      xv_q    <= xv_d;
      done_q  <= done_d;
    end
  end

  assign din_ready = hold_ready;
  assign x         = x_q;
  assign x_valid   = xv_q;
  assign word_done = done_q;
  assign busy      = (state_q != StIdle) || hold_full;

endmodule

// File: tb/tb_piso_bit_feeder.sv
// Self-checking bench: MSB-first and LSB-first feeders share stimulus and are
// compared every cycle against a bit-queue reference model.
module tb_piso_bit_feeder;

  localparam int unsigned W = 8;
`ifdef PISO_PARITY_EN
  localparam int unsigned Par = 1;
`else
  localparam int unsigned Par = 0;
`endif
  localparam int unsigned WordLen = W + Par;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [W-1:0] din = '0;
  logic         din_valid = 1'b0;

  logic rdy_m, x_m, xv_m, busy_m, wd_m;
  logic rdy_l, x_l, xv_l, busy_l, wd_l;

  piso_bit_feeder #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_m (
    .clk       (clk),
    .rst       (rst),
    .din       (din),
    .din_valid (din_valid),
    .din_ready (rdy_m),
    .x         (x_m),
    .x_valid   (xv_m),
    .busy      (busy_m),
    .word_done (wd_m)
  );

  piso_bit_feeder #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_l (
    .clk       (clk),
    .rst       (rst),
    .din       (din),
    .din_valid (din_valid),
    .din_ready (rdy_l),
    .x         (x_l),
    .x_valid   (xv_l),
    .busy      (busy_l),
    .word_done (wd_l)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Reference model: queue of bits still to be emitted plus a one-word hold slot.
  typedef struct packed {
    logic bm;
    logic bl;
    logic last;
  } mbit_t;

  mbit_t        mq[$];
  logic         m_hold_v = 1'b0;
  logic [W-1:0] m_hold_d = '0;
  logic         m_acc;

  function automatic void push_word(input logic [W-1:0] d);
    mbit_t b;
    for (int i = 0; i < W; i++) begin
      b.bm   = d[W-1-i];
      b.bl   = d[i];
      b.last = (i == W - 1) && (Par == 0);
      mq.push_back(b);
    end
    if (Par != 0) begin
      b.bm   = ^d;
      b.bl   = ^d;
      b.last = 1'b1;
      mq.push_back(b);
    end
  endfunction

  function automatic void model_reset();
    mq.delete();
    m_hold_v = 1'b0;
  endfunction

  function automatic void model_edge(input logic v, input logic [W-1:0] d);
    logic acc;
    acc   = v && !m_hold_v;
    m_acc = acc;
    if (mq.size() > 0) mq.delete(0);
    if (mq.size() == 0) begin
      if (m_hold_v) begin
        push_word(m_hold_d);
        m_hold_v = 1'b0;
      end else if (acc) begin
        push_word(d);
        acc = 1'b0;
      end
    end
    if (acc) begin
      m_hold_v = 1'b1;
      m_hold_d = d;
    end
  endfunction

  // {x_m, x_l, xv_m, xv_l, wd_m, wd_l, busy_m, busy_l, rdy_m, rdy_l}
  function automatic logic [9:0] exp_vec();
    mbit_t f;
    if (mq.size() > 0) begin
      f = mq[0];
      return {f.bm, f.bl, 2'b11, f.last, f.last, 2'b11, ~m_hold_v, ~m_hold_v};
    end
    return {6'b0, m_hold_v, m_hold_v, ~m_hold_v, ~m_hold_v};
  endfunction

  function automatic logic [9:0] obs_vec();
    return {x_m, x_l, xv_m, xv_l, wd_m, wd_l, busy_m, busy_l, rdy_m, rdy_l};
  endfunction

  task automatic tick(input logic v, input logic [W-1:0] d);
    din_valid = v;
    din       = d;
    @(posedge clk);
    model_edge(v, d);
    cyc++;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    din_valid = 1'b0;
    model_reset();
    #12;
    total++;
    if (obs_vec() !== 10'b00_0000_0011) begin
      bad++;
      $display("FAIL reset_state got=%b want=%b", obs_vec(), 10'b00_0000_0011);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_single_word();
    logic [W-1:0] byte_m, byte_l;
    int n, done_at;
    byte_m = '0; byte_l = '0; n = 0; done_at = 0;
    for (int i = 0; i < 14; i++) begin
      tick(i == 0, (i == 0) ? 8'hA8 : W'($urandom));
      total++;
      if (obs_vec() !== exp_vec()) begin
        bad++;
        $display("FAIL single_word cyc=%0d got=%b want=%b", cyc, obs_vec(), exp_vec());
      end
      if (xv_m) begin
        n++;
        if (n <= W) begin
          byte_m = {byte_m[W-2:0], x_m};
          byte_l = {x_l, byte_l[W-1:1]};
        end
        if (wd_m) done_at = n;
      end
    end
    total++;
    if (byte_m !== 8'hA8) begin
      bad++;
      $display("FAIL msb_serial got=%h want=%h", byte_m, 8'hA8);
    end
    total++;
    if (byte_l !== 8'hA8) begin
      bad++;
      $display("FAIL lsb_serial got=%h want=%h", byte_l, 8'hA8);
    end
    total++;
    if (done_at != WordLen || n != WordLen) begin
      bad++;
      $display("FAIL single_len done_at=%0d bits=%0d want=%0d", done_at, n, WordLen);
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] words [3];
    int idx, guard, nv, first, last, ndone;
    words[0] = 8'hAA; words[1] = 8'h55; words[2] = 8'hFF;
    idx = 0; guard = 0; nv = 0; first = -1; last = -1; ndone = 0;
    while (guard < 80) begin
      guard++;
      if (idx < 3) tick(1'b1, words[idx]);
      else         tick(1'b0, W'($urandom));
      if (idx < 3 && m_acc) idx++;
      total++;
      if (obs_vec() !== exp_vec()) begin
        bad++;
        $display("FAIL back_to_back cyc=%0d got=%b want=%b", cyc, obs_vec(), exp_vec());
      end
      if (xv_m) begin
        nv++;
        if (first < 0) first = guard;
        last = guard;
      end
      if (wd_m) ndone++;
      if (idx == 3 && mq.size() == 0 && !m_hold_v) break;
    end
    total++;
    if (nv != 3 * WordLen || (last - first + 1) != nv || ndone != 3) begin
      bad++;
      $display("FAIL b2b_stream valid=%0d span=%0d done=%0d want=%0d", nv, last - first + 1,
               ndone, 3 * WordLen);
    end
  endtask

  task automatic test_bypass();
    int guard;
    logic gap;
    tick(1'b1, 8'h3C);
    guard = 0;
    while (mq.size() != 1 && guard < 40) begin
      guard++;
      tick(1'b0, W'($urandom));
      total++;
      if (obs_vec() !== exp_vec()) begin
        bad++;
        $display("FAIL bypass_lead cyc=%0d got=%b want=%b", cyc, obs_vec(), exp_vec());
      end
    end
    total++;
    if (mq.size() != 1 || wd_m !== 1'b1) begin
      bad++;
      $display("FAIL bypass_align word_done=%b want=1", wd_m);
    end
    gap = 1'b0;
    for (int i = 0; i < WordLen + 4; i++) begin
      tick(i == 0, (i == 0) ? 8'h0F : W'($urandom));
      total++;
      if (obs_vec() !== exp_vec()) begin
        bad++;
        $display("FAIL bypass cyc=%0d got=%b want=%b", cyc, obs_vec(), exp_vec());
      end
      if (i < WordLen && !xv_m) gap = 1'b1;
    end
    total++;
    if (gap) begin
      bad++;
      $display("FAIL bypass_gap got=gap want=continuous");
    end
  endtask

  task automatic test_async_reset();
    tick(1'b1, 8'hA8);
    tick(1'b1, 8'h5A);
    tick(1'b0, 8'h00);
    tick(1'b0, 8'h00);
    total++;
    if (obs_vec() !== exp_vec() || !m_hold_v) begin
      bad++;
      $display("FAIL pre_reset got=%b want=%b", obs_vec(), exp_vec());
    end
    #3;
    rst = 1'b1;
    #1;
    model_reset();
    total++;
    if (obs_vec() !== 10'b00_0000_0011) begin
      bad++;
      $display("FAIL async_reset got=%b want=%b", obs_vec(), 10'b00_0000_0011);
    end
    #2;
    rst = 1'b0;
    for (int i = 0; i < WordLen + 4; i++) begin
      tick(1'b0, W'($urandom));
      total++;
      if (obs_vec() !== 10'b00_0000_0011) begin
        bad++;
        $display("FAIL post_reset cyc=%0d got=%b want=%b", cyc, obs_vec(), 10'b00_0000_0011);
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      tick($urandom_range(0, 3) != 0, W'($urandom));
      total++;
      if (obs_vec() !== exp_vec()) begin
        bad++;
        $display("FAIL random cyc=%0d got=%b want=%b", cyc, obs_vec(), exp_vec());
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_back_to_back();
    test_bypass();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
